// File: rtl/v_slide_pkg.sv
// Shared widths, direction and FSM state types for the vector slide
// row-sequenced index generator.
package v_slide_pkg;

  function automatic int row_w(input int loc_per_lane);
    return $clog2(loc_per_lane * 32);
  endfunction

  function automatic int sa_w(input int lanes, input int loc_per_lane);
    return $clog2(loc_per_lane * 32 * lanes);
  endfunction

  function automatic int ln_w(input int lanes);
    return $clog2(lanes);
  endfunction

  typedef enum logic {
    SLIDE_UP   = 1'b0,
    SLIDE_DOWN = 1'b1
  } slide_dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } slide_state_e;

endpackage

// File: rtl/v_slide_lane_calc.sv
// Per-lane slide index calculation: for one destination lane of a row,
// derives the source row, write enable and zero-fill flag.
module v_slide_lane_calc
  import v_slide_pkg::*;
#(
  parameter int VLANE_NUM         = 8,
  parameter int VREG_LOC_PER_LANE = 8,
  parameter int LANE              = 0,
  localparam int ROW_W            = row_w(VREG_LOC_PER_LANE),
  localparam int SA_W             = sa_w(VLANE_NUM, VREG_LOC_PER_LANE),
  localparam int LN_W             = ln_w(VLANE_NUM)
) (
  input  logic [ROW_W-1:0] row_i,
  input  logic [SA_W-1:0]  sa_i,
  input  logic [SA_W:0]    vl_i,
  input  slide_dir_e       dir_i,
  output logic [ROW_W-1:0] src_row_o,
  output logic             mask_o,
  output logic             zero_o
);

  localparam int EW = SA_W + 1;

  logic [EW-1:0] d;
  logic [EW-1:0] sa_ext;
  logic [EW-1:0] s;

  // Element index of this lane in the row; lanes are a power of two.
  assign d      = (EW'(row_i) << LN_W) | EW'(LANE);
  assign sa_ext = EW'(sa_i);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave a value held and infer a latch.
  always_comb begin
    s         = '0;
    src_row_o = '0;
    mask_o    = 1'b0;
    zero_o    = 1'b0;
    if (dir_i == SLIDE_UP) begin
      if (d >= sa_ext) begin
        s         = d - sa_ext;
        mask_o    = (d < vl_i);
        src_row_o = ROW_W'(s >> LN_W);
      end
    end else begin
      s         = d + sa_ext;
      mask_o    = (d < vl_i);
      zero_o    = mask_o && (s >= vl_i);
      src_row_o = ROW_W'(s >> LN_W);
    end
  end

endmodule

// File: rtl/v_slide_offset_gen.sv
// Accepts one slide command and emits one registered descriptor per
// destination row (rotation, per-lane source row, write mask, zero-fill).
module v_slide_offset_gen
  import v_slide_pkg::*;
#(
  parameter int VLANE_NUM         = 8,
  parameter int VREG_LOC_PER_LANE = 8,
  localparam int ROW_W            = row_w(VREG_LOC_PER_LANE),
  localparam int SA_W             = sa_w(VLANE_NUM, VREG_LOC_PER_LANE),
  localparam int LN_W             = ln_w(VLANE_NUM)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  output logic                                ready_o,
  input  logic                                dir_i,
  input  logic [SA_W-1:0]                     shift_amount_i,
  input  logic [SA_W:0]                       vl_i,
  output logic                                row_valid_o,
  input  logic                                row_ready_i,
  output logic [ROW_W-1:0]                    row_idx_o,
  output logic [LN_W-1:0]                     rot_o,
  output logic [VLANE_NUM-1:0][ROW_W-1:0]     src_row_o,
  output logic [VLANE_NUM-1:0]                lane_mask_o,
  output logic [VLANE_NUM-1:0]                zero_o,
  output logic                                done_o
);

  localparam int               EXT     = SA_W + 2;
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  slide_state_e state_q, state_d;
  slide_dir_e   dir_in, dir_q;
  logic [SA_W-1:0]  sa_q;
  logic [SA_W:0]    vl_q;
  logic [ROW_W-1:0] last_row_q;

  logic [EXT-1:0]   n_rows_in, last_wide;
  logic [ROW_W-1:0] first_row_in, last_row_in;
  logic             empty_in;
  logic             load, advance, finish;

  logic [ROW_W-1:0]                calc_row;
  logic [SA_W-1:0]                 calc_sa;
  logic [SA_W:0]                   calc_vl;
  slide_dir_e                      calc_dir;
  logic [VLANE_NUM-1:0][ROW_W-1:0] calc_src;
  logic [VLANE_NUM-1:0]            calc_mask, calc_zero;

  // Row range of an incoming command; vl above VLMAX is clamped to the last row.
  assign dir_in       = slide_dir_e'(dir_i);
  assign n_rows_in    = (EXT'(vl_i) + EXT'(VLANE_NUM - 1)) >> LN_W;
  assign last_wide    = n_rows_in - EXT'(1);
  assign last_row_in  = (last_wide > EXT'(ROW_MAX)) ? ROW_MAX : ROW_W'(last_wide);
  assign first_row_in = (dir_in == SLIDE_UP) ? ROW_W'(shift_amount_i >> LN_W) : '0;
  assign empty_in     = (vl_i == '0) ||
                        ((dir_in == SLIDE_UP) && (EXT'(shift_amount_i >> LN_W) >= n_rows_in));

  // In IDLE the lane calculators see the incoming command's first row; in RUN
  // they precompute the row after the one currently presented.
  always_comb begin
    if (state_q == IDLE) begin
      calc_row = first_row_in;
      calc_sa  = shift_amount_i;
      calc_vl  = vl_i;
      calc_dir = dir_in;
    end else begin
      calc_row = row_idx_o + ROW_W'(1);
      calc_sa  = sa_q;
      calc_vl  = vl_q;
      calc_dir = dir_q;
    end
  end

  for (genvar j = 0; j < VLANE_NUM; j++) begin : g_lane
    v_slide_lane_calc #(
      .VLANE_NUM        (VLANE_NUM),
      .VREG_LOC_PER_LANE(VREG_LOC_PER_LANE),
      .LANE             (j)
    ) u_calc (
      .row_i    (calc_row),
      .sa_i     (calc_sa),
      .vl_i     (calc_vl),
      .dir_i    (calc_dir),
      .src_row_o(calc_src[j]),
      .mask_o   (calc_mask[j]),
      .zero_o   (calc_zero[j])
    );
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = empty_in ? FIN : RUN;
        end
      end
      RUN: begin
        if (row_ready_i) begin
          if (row_idx_o == last_row_q) begin
            finish  = 1'b1;
            state_d = FIN;
          end else begin
            advance = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q       <= SLIDE_UP;
      sa_q        <= '0;
      vl_q        <= '0;
      last_row_q  <= '0;
      row_idx_o   <= '0;
      rot_o       <= '0;
      src_row_o   <= '0;
      lane_mask_o <= '0;
      zero_o      <= '0;
    end else begin
      if (load) begin
        dir_q      <= dir_in;
        sa_q       <= shift_amount_i;
        vl_q       <= vl_i;
        last_row_q <= last_row_in;
      end
      if ((load && !empty_in) || advance) begin
        row_idx_o   <= calc_row;
        src_row_o   <= calc_src;
        lane_mask_o <= calc_mask;
        zero_o      <= calc_zero;
        if (load) rot_o <= shift_amount_i[LN_W-1:0];
      end else if (finish) begin
        row_idx_o   <= '0;
        rot_o       <= '0;
        src_row_o   <= '0;
        lane_mask_o <= '0;
        zero_o      <= '0;
      end
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign row_valid_o = (state_q == RUN);
  assign done_o      = (state_q == FIN);

endmodule
